multicycle_fsm: RTL and testbench
=================================

MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1, meaning 1 = honour mem_ready and 0 = treat mem_ready as constant 1.
REQ-002 Port: CLK, input, 1, system clock; all state changes occur on the rising edge.
REQ-003 Port: Reset, input, 1, asynchronous, active-low reset.
REQ-004 Port: OP, input, 6, instruction opcode from the instruction register.
REQ-005 Port: mem_ready, input, 1, memory has completed the current access this cycle.
REQ-006 Port: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, Branch, PCWrite, jump, output, 1 each, datapath controls.
REQ-007 Port: ALUSrcB, output, 2, ALU B select: 00 = regB, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-008 Port: AluOP, output, 3, ALU op class: 000 = add, 001 = sub, 010 = decode by Func.
REQ-009 Port: state, output, 4, current state encoding, for debug.
REQ-010 Port: illegal_op, output, 1, one-cycle pulse on an unsupported opcode.

Function
REQ-011 The FSM SHALL be Moore type: every control output is a pure decode of state, and of mem_ready where noted. Unlisted outputs SHALL be 0.
REQ-012 The states SHALL be encoded as follows: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-013 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, AluOP=000 and PCSrc=0. It SHALL assert IRWrite and PCWrite only while mem_ready=1, and SHALL move to DECODE when mem_ready=1, otherwise hold.
REQ-014 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and AluOP=000, then branch on OP:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXEC
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with illegal_op=1 for that one cycle
REQ-015 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10 and AluOP=000, then go to MEMRD if OP=100011, otherwise MEMWR.
REQ-016 MEMRD SHALL drive IorD=1 and move to MEMWB when mem_ready=1, otherwise hold.
REQ-017 MEMWB SHALL drive RegDst=0, MemtoReg=1 and RegWrite=1, then go to FETCH.
REQ-018 MEMWR SHALL drive IorD=1 and MemWrite=1 continuously, and move to FETCH when mem_ready=1.
REQ-019 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and AluOP=010, then go to ALUWB.
REQ-020 ALUWB SHALL drive RegDst=1, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, AluOP=001, PCSrc=1 and Branch=1, then go to FETCH.
REQ-022 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10 and AluOP=000, then go to ADDIWB.
REQ-023 ADDIWB SHALL drive RegDst=0, MemtoReg=0 and RegWrite=1, then go to FETCH.
REQ-024 JUMP SHALL drive jump=1 and PCWrite=1, then go to FETCH.
REQ-025 Instruction latency SHALL be as follows, counting cycles with zero wait states:
- lw: 5
- sw: 4
- R-type: 4
- addi: 4
- beq: 3
- j: 3
- illegal opcode: 2
Each wait cycle adds exactly 1.
REQ-026 An unused encoding (12-15) SHALL go to FETCH on the next edge and SHALL drive all outputs 0.
REQ-027 OP SHALL be sampled only in DECODE and MEMADR; OP changes in any other state SHALL have no effect.
REQ-028 With MEM_WAIT_EN=0, no state SHALL hold.

Reset
REQ-029 While Reset=0, state SHALL be FETCH and illegal_op SHALL be 0 immediately, without waiting for CLK. IRWrite and PCWrite SHALL be forced to 0 during reset.
REQ-030 After Reset rises, the first rising CLK edge SHALL evaluate FETCH normally.
REQ-031 Reset asserted in any state, including a MemWrite hold in MEMWR, SHALL abort the operation; MemWrite and RegWrite SHALL drop asynchronously.

Verification
REQ-032 lw, mem_ready=1 constant -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-033 sw, mem_ready low for 2 cycles in MEMWR -> MemWrite high for exactly 3 cycles; sequence 0,1,2,5,5,5,0.
REQ-034 FETCH with mem_ready low for 3 cycles -> IRWrite and PCWrite low for 3 cycles, then high for exactly 1 cycle.
REQ-035 beq, then j -> sequence 0,1,8,0,1,11,0; Branch=1 and AluOP=001 in state 8; jump=1 and PCWrite=1 in state 11.
REQ-036 OP=111111 -> sequence 0,1,0; illegal_op=1 in the DECODE cycle only; RegWrite and MemWrite never 1.
REQ-037 Reset pulled low mid-ALUWB -> RegWrite=0 and state=0 within the same cycle; after release, the sequence restarts with FETCH.

Source files
------------

// File: rtl/multicycle_fsm.sv
// multicycle_fsm -- Moore control unit for a multicycle MIPS-style datapath.
//
// Ports:
//   CLK        : system clock, rising edge active
//   Reset      : asynchronous active-low reset (state -> FETCH)
//   OP[5:0]    : opcode from the instruction register
//   mem_ready  : memory completed the current access this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, PCSrc, Branch, PCWrite, jump : datapath controls
//   ALUSrcB[1:0] : 00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   AluOP[2:0]   : 000 add, 001 sub, 010 decode by Func
//   state[3:0]   : current state encoding (debug)
//   illegal_op   : one-cycle pulse in DECODE on an unsupported opcode
//
// Parameter:
//   MEM_WAIT_EN : 1 = honour mem_ready, 0 = treat mem_ready as 1

module multicycle_fsm #(
  parameter int unsigned MEM_WAIT_EN = 1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] OP,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCSrc,
  output logic       Branch,
  output logic       PCWrite,
  output logic       jump,
  output logic [1:0] ALUSrcB,
  output logic [2:0] AluOP,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur, nxt;
  logic   mr;

  assign mr    = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state = cur;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cur <= FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt        = cur;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    PCSrc      = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    jump       = 1'b0;
    ALUSrcB    = 2'b00;
    AluOP      = 3'b000;
    illegal_op = 1'b0;

    case (cur)
      FETCH: begin
        ALUSrcB = 2'b01;
        // The state register already sits in FETCH during reset, so the
        // fetch strobes are additionally gated by the reset pin itself.
        IRWrite = mr & Reset;
        PCWrite = mr & Reset;
        if (mr) nxt = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYP:      nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default: begin
            nxt        = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (OP == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (mr) nxt = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mr) nxt = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        AluOP   = 3'b010;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        AluOP   = 3'b001;
        PCSrc   = 1'b1;
        Branch  = 1'b1;
        nxt     = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      JUMP: begin
        jump    = 1'b1;
        PCWrite = 1'b1;
        nxt     = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_fsm.sv
// tb_multicycle_fsm -- directed bench for multicycle_fsm.
// Each step applies inputs just after a rising edge and checks state,
// the packed control vector and illegal_op at the following falling edge.
// Control vector bit order:
//   [15] IorD [14] MemWrite [13] IRWrite [12] RegDst [11] MemtoReg
//   [10] RegWrite [9] ALUSrcA [8] PCSrc [7] Branch [6] PCWrite [5] jump
//   [4:3] ALUSrcB [2:0] AluOP

module tb_multicycle_fsm;

  logic       CLK;
  logic       Reset;
  logic [5:0] OP;
  logic       mem_ready;

  logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic ALUSrcA, PCSrc, Branch, PCWrite, jump, illegal_op;
  logic [1:0] ALUSrcB;
  logic [2:0] AluOP;
  logic [3:0] state;
  logic [15:0] ctl;

  logic [15:0] ctl0;
  logic [3:0]  state0;
  logic        ill0;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ILL  = 6'b111111;

  localparam logic [15:0] C_RST    = 16'h0008;
  localparam logic [15:0] C_FETCH  = 16'h2048;
  localparam logic [15:0] C_FWAIT  = 16'h0008;
  localparam logic [15:0] C_DECODE = 16'h0018;
  localparam logic [15:0] C_MEMADR = 16'h0210;
  localparam logic [15:0] C_MEMRD  = 16'h8000;
  localparam logic [15:0] C_MEMWB  = 16'h0C00;
  localparam logic [15:0] C_MEMWR  = 16'hC000;
  localparam logic [15:0] C_EXEC   = 16'h0202;
  localparam logic [15:0] C_ALUWB  = 16'h1400;
  localparam logic [15:0] C_BRANCH = 16'h0381;
  localparam logic [15:0] C_ADDIEX = 16'h0210;
  localparam logic [15:0] C_ADDIWB = 16'h0400;
  localparam logic [15:0] C_JUMP   = 16'h0060;

  multicycle_fsm #(.MEM_WAIT_EN(1)) dut (
    .CLK(CLK), .Reset(Reset), .OP(OP), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCSrc(PCSrc), .Branch(Branch), .PCWrite(PCWrite), .jump(jump),
    .ALUSrcB(ALUSrcB), .AluOP(AluOP), .state(state), .illegal_op(illegal_op)
  );

  multicycle_fsm #(.MEM_WAIT_EN(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .OP(OP), .mem_ready(mem_ready),
    .IorD(ctl0[15]), .MemWrite(ctl0[14]), .IRWrite(ctl0[13]), .RegDst(ctl0[12]),
    .MemtoReg(ctl0[11]), .RegWrite(ctl0[10]), .ALUSrcA(ctl0[9]),
    .PCSrc(ctl0[8]), .Branch(ctl0[7]), .PCWrite(ctl0[6]), .jump(ctl0[5]),
    .ALUSrcB(ctl0[4:3]), .AluOP(ctl0[2:0]), .state(state0), .illegal_op(ill0)
  );

  assign ctl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, PCSrc, Branch, PCWrite, jump, ALUSrcB, AluOP};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                      input logic [3:0] est, input logic [15:0] ectl,
                      input logic eill, input string tag);
    @(posedge CLK);
    #1;
    Reset     = rst;
    OP        = op;
    mem_ready = mr;
    @(negedge CLK);
    chk({tag, "_state"}, {12'd0, state}, {12'd0, est});
    chk({tag, "_ctl"}, ctl, ectl);
    chk({tag, "_ill"}, {15'd0, illegal_op}, {15'd0, eill});
  endtask

  // Assert reset in the middle of the current cycle and check the
  // outputs fall without any clock edge.
  task automatic mid_reset(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    chk({tag, "_state"}, {12'd0, state}, 16'd0);
    chk({tag, "_ctl"}, ctl, C_RST);
    chk({tag, "_ill"}, {15'd0, illegal_op}, 16'd0);
  endtask

  initial begin
    Reset     = 1'b0;
    OP        = RT;
    mem_ready = 1'b1;
    #2;
    chk("rst_state", {12'd0, state}, 16'd0);
    chk("rst_ctl", ctl, C_RST);
    chk("rst_ill", {15'd0, illegal_op}, 16'd0);

    // lw, no waits; OP changes in MEMRD/MEMWB must be ignored
    step(1, LW,  1, 4'd0, C_FETCH,  0, "lw_fetch");
    step(1, LW,  1, 4'd1, C_DECODE, 0, "lw_decode");
    step(1, LW,  1, 4'd2, C_MEMADR, 0, "lw_memadr");
    step(1, ILL, 1, 4'd3, C_MEMRD,  0, "lw_memrd");
    step(1, ILL, 1, 4'd4, C_MEMWB,  0, "lw_memwb");

    // sw with two wait cycles in MEMWR
    step(1, ILL, 1, 4'd0, C_FETCH,  0, "sw_fetch");
    step(1, SW,  1, 4'd1, C_DECODE, 0, "sw_decode");
    step(1, SW,  1, 4'd2, C_MEMADR, 0, "sw_memadr");
    step(1, SW,  0, 4'd5, C_MEMWR,  0, "sw_memwr1");
    chk("nowait_memwr_state", {12'd0, state0}, 16'd5);
    step(1, SW,  0, 4'd5, C_MEMWR,  0, "sw_memwr2");
    chk("nowait_fetch_state", {12'd0, state0}, 16'd0);
    chk("nowait_fetch_ctl", ctl0, C_FETCH);
    chk("nowait_ill", {15'd0, ill0}, 16'd0);
    step(1, SW,  1, 4'd5, C_MEMWR,  0, "sw_memwr3");

    // FETCH stalls three cycles, then fetches
    step(1, RT, 0, 4'd0, C_FWAIT,  0, "fwait1");
    step(1, RT, 0, 4'd0, C_FWAIT,  0, "fwait2");
    step(1, RT, 0, 4'd0, C_FWAIT,  0, "fwait3");
    step(1, RT, 1, 4'd0, C_FETCH,  0, "fwait_go");

    // R-type
    step(1, RT, 1, 4'd1, C_DECODE, 0, "rt_decode");
    step(1, RT, 1, 4'd6, C_EXEC,   0, "rt_exec");
    step(1, RT, 1, 4'd7, C_ALUWB,  0, "rt_aluwb");

    // beq then j
    step(1, BEQ, 1, 4'd0,  C_FETCH,  0, "beq_fetch");
    step(1, BEQ, 1, 4'd1,  C_DECODE, 0, "beq_decode");
    step(1, JMP, 1, 4'd8,  C_BRANCH, 0, "beq_branch");
    step(1, JMP, 1, 4'd0,  C_FETCH,  0, "j_fetch");
    step(1, JMP, 1, 4'd1,  C_DECODE, 0, "j_decode");
    step(1, JMP, 1, 4'd11, C_JUMP,   0, "j_jump");

    // addi
    step(1, ADDI, 1, 4'd0,  C_FETCH,  0, "addi_fetch");
    step(1, ADDI, 1, 4'd1,  C_DECODE, 0, "addi_decode");
    step(1, ADDI, 1, 4'd9,  C_ADDIEX, 0, "addi_ex");
    step(1, ADDI, 1, 4'd10, C_ADDIWB, 0, "addi_wb");

    // illegal opcode
    step(1, ILL, 1, 4'd0, C_FETCH,  0, "ill_fetch");
    step(1, ILL, 1, 4'd1, C_DECODE, 1, "ill_decode");
    step(1, ILL, 1, 4'd0, C_FETCH,  0, "ill_back");

    // reset asserted mid-ALUWB, then restart from FETCH
    step(1, RT, 1, 4'd1, C_DECODE, 0, "rr_decode");
    step(1, RT, 1, 4'd6, C_EXEC,   0, "rr_exec");
    step(1, RT, 1, 4'd7, C_ALUWB,  0, "rr_aluwb");
    mid_reset("rr_abort");
    step(1, SW, 1, 4'd0, C_FETCH,  0, "rr_fetch");
    step(1, SW, 1, 4'd1, C_DECODE, 0, "rr_decode2");

    // reset asserted during a MEMWR hold
    step(1, SW, 1, 4'd2, C_MEMADR, 0, "wr_memadr");
    step(1, SW, 0, 4'd5, C_MEMWR,  0, "wr_memwr");
    mid_reset("wr_abort");
    step(1, SW, 1, 4'd0, C_FETCH,  0, "wr_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
